// File: rtl/regfile_wb_ctrl.sv
// Register-file write-side controller: arbitrates EX/MEM writeback onto one registered
// write port and tracks per-register pending writes to flag read hazards.
module regfile_wb_ctrl #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int REG_NUM = 32,
  parameter int CNT_W   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_rd,
  output logic              issue_ready,
  input  logic              ex_valid,
  input  logic [ADDR_W-1:0] ex_rd,
  input  logic [DATA_W-1:0] ex_data,
  output logic              ex_ready,
  input  logic              mem_valid,
  input  logic [ADDR_W-1:0] mem_rd,
  input  logic [DATA_W-1:0] mem_data,
  output logic              mem_ready,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  input  logic [ADDR_W-1:0] raddr3,
  output logic              rs1_busy,
  output logic              rs2_busy,
  output logic              rs3_busy
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Handshakes: a transfer happens on a rising edge where valid && ready.
  // A source with valid high and ready low must hold rd/data stable.
  logic              r_we;
  logic [ADDR_W-1:0] r_waddr;
  logic [DATA_W-1:0] r_wdata;
  logic [CNT_W-1:0]  r_cnt [REG_NUM];

  logic              w_mem_acc;
  logic              w_ex_acc;
  logic [ADDR_W-1:0] w_sel_rd;
  logic [DATA_W-1:0] w_sel_data;
  logic              w_commit;
  logic              w_issue_hs;
  logic              w_dec_issue;

  always_comb begin
    w_mem_acc  = mem_valid && !rst;
    w_ex_acc   = ex_valid && !rst && !mem_valid;
    w_sel_rd   = mem_valid ? mem_rd : ex_rd;
    w_sel_data = mem_valid ? mem_data : ex_data;
    w_commit   = (w_mem_acc || w_ex_acc) && (w_sel_rd != '0);
  end

  // A commit of issue_rd this edge frees a slot, so a saturated register can still accept.
  assign w_dec_issue = r_we && (r_waddr == issue_rd);
  assign issue_ready = !rst && ((issue_rd == '0) || (r_cnt[issue_rd] != CNT_MAX) || w_dec_issue);
  assign w_issue_hs  = issue_valid && issue_ready && (issue_rd != '0);

  assign mem_ready = !rst;
  assign ex_ready  = !rst && !mem_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_we    <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
    end else if (w_commit) begin
      r_we    <= 1'b1;
      r_waddr <= w_sel_rd;
      r_wdata <= w_sel_data;
    end else begin
      r_we    <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    for (int r = 0; r < REG_NUM; r++) begin
      logic w_inc;
      logic w_dec;
      w_inc = w_issue_hs && (issue_rd == ADDR_W'(r));
      w_dec = r_we && (r_waddr == ADDR_W'(r));
      if (rst || r == 0) begin
        r_cnt[r] <= '0;
      end else if (w_inc && !w_dec && r_cnt[r] != CNT_MAX) begin
        r_cnt[r] <= r_cnt[r] + 1'b1;
      end else if (w_dec && !w_inc && r_cnt[r] != '0) begin
        r_cnt[r] <= r_cnt[r] - 1'b1;
      end
    end
  end

  assign rs1_busy = (raddr1 != '0) && (r_cnt[raddr1] != '0);
  assign rs2_busy = (raddr2 != '0) && (r_cnt[raddr2] != '0);
  assign rs3_busy = (raddr3 != '0) && (r_cnt[raddr3] != '0);

  assign we    = r_we;
  assign waddr = r_waddr;
  assign wdata = r_wdata;

endmodule
